ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register.
- Consumes the latched operands and the decoded mul/div op from ID/EX.
- Produces 64-bit HI/LO results.
- Holds the front of the pipeline through a stall output while an operation is in progress.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage instruction is a mul/div; level, held by ID/EX while stalled.
- op  input  2  00 MULU, 01 MUL signed, 10 DIVU, 11 DIV signed.
- opa  input  WIDTH  operand A (multiplicand / dividend).
- opb  input  WIDTH  operand B (multiplier / divisor).
- flush  input  1  synchronous abort of the EX-stage instruction.
- stall  output  1  freeze PC, IF/ID and ID/EX this cycle.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse; hi/lo hold the new result.
- hi  output  WIDTH  MUL: upper product; DIV: remainder.
- lo  output  WIDTH  MUL: lower product; DIV: quotient.
- div_by_zero  output  1  valid with done; 1 if a divide had opb==0.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; hi, lo, done, div_by_zero, busy = 0; internal counter and working registers = 0. An operation in flight is discarded.
- States: IDLE, CALC, DONE.
- IDLE -> CALC when start=1 and flush=0, except divide with opb==0.
  - Latch op.
  - For signed ops, latch |opa|, |opb| and the result signs.
  - Clear the working registers. Counter=0.
- IDLE -> DONE directly on a divide with opb==0: lo=all ones, hi=opa, div_by_zero=1.
- CALC: one bit per cycle.
  - Multiply: shift-add.
  - Divide: restoring division.
  - Counter increments each cycle.
  - At counter==WIDTH-1, the edge writes the sign-corrected result to hi/lo and moves to DONE.
- DONE: done=1 for exactly one cycle. Next edge -> IDLE unconditionally. start is ignored in DONE, because it is still the completed instruction.
- Latency:
  - Start sampled at edge E0.
  - hi/lo are updated at E32.
  - done is high in the cycle after E32, i.e. 33 cycles after acceptance.
  - Divide by zero: done is high in the cycle after E0.
- stall = (state==IDLE & start & ~flush) | (state==CALC). stall is low in DONE, so the instruction advances with hi/lo valid.
- Signed correction:
  - Product is negated (64-bit two's complement) when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Most-negative operands use unsigned magnitude, so no special case is needed:
    - 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Result registers:
  - hi/lo change only at completion (the E32 edge or the divide-by-zero transition) and hold until the next completion.
  - Working registers are separate from hi/lo.
- div_by_zero:
  - Updated at each completion; 0 for multiplies and non-zero divides.
  - Holds its value until the next completion.
- flush:
  - In CALC or DONE: next state IDLE; hi/lo/div_by_zero unchanged; no done pulse.
  - flush and start both high in IDLE: flush wins; stall=0; nothing accepted.
- Changes on start/op/opa/opb during CALC are ignored; operands are latched only at acceptance.
- Back-to-back ops: the second is accepted in IDLE, one cycle after DONE.

Test Plan:
- MULU opa=0xFFFFFFFF opb=0xFFFFFFFF -> stall high for 33 cycles starting in the acceptance cycle, done 33 cycles after acceptance, hi=0xFFFFFFFE lo=0x00000001, div_by_zero=0.
- MUL opa=0xFFFFFFF9 (-7) opb=3 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Also MUL 0x80000000*0x80000000 -> hi=0x40000000 lo=0.
- DIV opa=-7 opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Also DIVU 100/7 -> lo=14, hi=2.
- DIVU opa=0x1234 opb=0 -> done the cycle after acceptance, lo=0xFFFFFFFF hi=0x1234, div_by_zero=1, stall high only in the acceptance cycle.
- Flush at CALC cycle 10 (previous result hi=lo=0x55) -> IDLE next cycle, no done, hi/lo stay 0x55. Also flush=start=1 in IDLE -> stall=0, stays IDLE.
- Assert rst low mid-CALC -> all outputs 0 immediately (asynchronous). Release reset, then run MULU 6*7 -> lo=42 hi=0, normal latency.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Handshake and result bundle between the ID/EX stage and the EX-stage
// iterative multiply/divide unit.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  // Pipeline side: issues operations, receives stall and results.
  modport master (
    output start, op, opa, opb, flush,
    input  stall, busy, done, hi, lo, div_by_zero
  );

  // Unit side.
  modport slave (
    input  start, op, opa, opb, flush,
    output stall, busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage. One result bit per cycle:
// MSB-first shift-add for multiply, restoring division for divide. Signed
// operations run on magnitudes and are sign-corrected on the final edge.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input logic        clock,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic             neg_q;
  logic             rneg_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] wh;
  logic [WIDTH-1:0] wl;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;
  logic             busy_q;

  logic [WIDTH-1:0]   nxt_wh;
  logic [WIDTH-1:0]   nxt_wl;
  logic [2*WIDTH-1:0] prod_sh;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod_fin;
  logic               abit;

  // Magnitude of an operand; the most negative value maps to its unsigned
  // magnitude, so no special case is needed downstream.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_signed);
    logic signed [WIDTH-1:0] n;
    n = -v;
    if (is_signed && v[WIDTH-1]) return $unsigned(n);
    return $unsigned(v);
  endfunction

  // Conditional two's-complement negation of a single-width value.
  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v,
                                              input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negation of a double-width product.
  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v,
                                                 input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // One iteration of the datapath: next working registers and final result.
  always_comb begin
    abit    = ma[WIDTH-1];
    prod_sh = {wh, wl} << 1;
    if (abit) prod_sh = prod_sh + {{WIDTH{1'b0}}, mb};
    rem_sh  = {wh, abit};
    trial   = rem_sh - {1'b0, mb};
    nxt_wh  = prod_sh[2*WIDTH-1:WIDTH];
    nxt_wl  = prod_sh[WIDTH-1:0];
    if (op_q[1]) begin
      nxt_wh = trial[WIDTH] ? {wh[WIDTH-2:0], abit} : trial[WIDTH-1:0];
      nxt_wl = {wl[WIDTH-2:0], ~trial[WIDTH]};
    end
    prod_fin = cneg_2w({nxt_wh, nxt_wl}, neg_q);
  end

  // Control FSM, working registers and result registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      cnt    <= '0;
      ma     <= '0;
      mb     <= '0;
      wh     <= '0;
      wl     <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            busy_q <= 1'b1;
            if (bus.op[1] && (bus.opb == '0)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              hi_q   <= bus.opa;
              lo_q   <= '1;
              dbz_q  <= 1'b1;
            end else begin
              state  <= S_CALC;
              op_q   <= bus.op;
              neg_q  <= bus.op[0] & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
              rneg_q <= bus.op[0] & bus.opa[WIDTH-1];
              ma     <= mag(bus.opa, bus.op[0]);
              mb     <= mag(bus.opb, bus.op[0]);
              wh     <= '0;
              wl     <= '0;
              cnt    <= '0;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            wh  <= nxt_wh;
            wl  <= nxt_wl;
            ma  <= ma << 1;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              dbz_q  <= 1'b0;
              if (op_q[1]) begin
                hi_q <= cneg_w(nxt_wh, rneg_q);
                lo_q <= cneg_w(nxt_wl, neg_q);
              end else begin
                hi_q <= prod_fin[2*WIDTH-1:WIDTH];
                lo_q <= prod_fin[WIDTH-1:0];
              end
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall covers the acceptance cycle and every iteration; gated by reset so
  // all outputs read zero while reset is held.
  assign bus.stall = rst & (((state == S_IDLE) & bus.start & ~bus.flush) |
                            (state == S_CALC));
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: a vector table plus randomised ops checked through a
// result scoreboard, and hand-written flush and reset sequences.
module tb_ex_muldiv;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         edbz;
  } vec_t;

  typedef struct {
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         edbz;
  } exp_t;

  logic clock;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t exp_q[$];
  vec_t vt[12];

  ex_muldiv_if #(.WIDTH(W)) bus ();

  ex_muldiv #(.WIDTH(W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    #1;
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hi", 64'(bus.hi), 64'(e.eh));
        chk("lo", 64'(bus.lo), 64'(e.el));
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.edbz));
      end
    end
  end

  // Issue one operation, hold start while stalled, check latency and stall length.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edbz);
    int cyc;
    int stalls;
    int exp_lat;
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    exp_q.push_back('{eh, el, edbz});
    exp_lat = edbz ? 1 : W + 1;
    #1;
    cyc    = 0;
    stalls = 0;
    while (!bus.done && cyc < 100) begin
      if (bus.stall) stalls++;
      @(negedge clock);
      #1;
      cyc++;
      if (cyc == 5) begin
        bus.op  = 2'($urandom);
        bus.opa = $urandom;
        bus.opb = $urandom;
      end
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("stall_cycles", 64'(stalls), 64'(exp_lat));
    chk("stall_in_done", 64'(bus.stall), 64'd0);
    bus.start = 1'b0;
  endtask

  initial begin
    vt[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[1]  = '{2'b01, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vt[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[5]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vt[6]  = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vt[7]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vt[8]  = '{2'b01, 32'd0,        32'hFFFFFFFF, 32'd0,        32'd0,        1'b0};
    vt[9]  = '{2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vt[10] = '{2'b10, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0};
    vt[11] = '{2'b00, 32'd65536,    32'd65536,    32'd1,        32'd0,        1'b0};

    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.opa   = '0;
    bus.opb   = '0;

    repeat (3) @(negedge clock);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, vt[i].edbz);

    // Randomised operations against a behavioural reference.
    for (int i = 0; i < 12; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b, eh, el;
      logic [63:0]  p;
      op = 2'(i % 4);
      a  = $urandom;
      b  = $urandom;
      if (op[1] && b == 0) b = 32'd3;
      if (op == 2'b11 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
      case (op)
        2'b00: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
        2'b01: begin
          p = 64'(longint'($signed(a)) * longint'($signed(b)));
          eh = p[63:32]; el = p[31:0];
        end
        2'b10: begin el = a / b; eh = a % b; end
        default: begin
          el = 32'($signed(a) / $signed(b));
          eh = 32'($signed(a) % $signed(b));
        end
      endcase
      run_op(op, a, b, eh, el, 1'b0);
    end

    // Leave hi=lo=0x55, then flush an operation mid-calculation.
    run_op(2'b10, 32'h1CE3, 32'h56, 32'h55, 32'h55, 1'b0);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opa   = 32'hFFFFFFFF;
    bus.opb   = 32'hFFFFFFFF;
    repeat (10) @(negedge clock);
    #1;
    chk("pre_flush_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clock);
    #1;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_start_stall", 64'(bus.stall), 64'd0);
    repeat (3) @(negedge clock);
    #1;
    chk("flush_hold_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (40) @(negedge clock);
    #1;
    chk("flush_hi", 64'(bus.hi), 64'h55);
    chk("flush_lo", 64'(bus.lo), 64'h55);

    // Asynchronous reset in the middle of a calculation.
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.opa   = 32'hFFFFFFFF;
    bus.opb   = 32'd3;
    repeat (10) @(negedge clock);
    #2;
    rst = 1'b0;
    #1;
    chk("async_busy", 64'(bus.busy), 64'd0);
    chk("async_stall", 64'(bus.stall), 64'd0);
    chk("async_hi", 64'(bus.hi), 64'd0);
    chk("async_lo", 64'(bus.lo), 64'd0);
    chk("async_done", 64'(bus.done), 64'd0);
    bus.start = 1'b0;
    exp_q.delete();
    @(negedge clock);
    rst = 1'b1;
    run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
